// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM:
// opcodes, state encoding and datapath select encodings.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_JAL    = 4'd11,
        S_ADDIEX = 4'd12,
        S_ADDIWB = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        SRCB_B       = 2'd0,
        SRCB_FOUR    = 2'd1,
        SRCB_IMM     = 2'd2,
        SRCB_IMM_SH2 = 2'd3
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'd0,
        PC_ALUOUT = 2'd1,
        PC_JUMP   = 2'd2
    } pc_source_t;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } reg_dst_t;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'd0,
        WB_MDR    = 2'd1,
        WB_PC     = 2'd2
    } mem_to_reg_t;

    // States that own the memory port and wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle main controller and the datapath.
// master = controller, slave = datapath / memory side.
interface mips_multicycle_ctrl_if;

    logic       run;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_beq;
    logic       pc_write_bne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_err;
    logic [3:0] state;

    modport master (
        input  run, opcode, mem_ready,
        output pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op, mem_err, state
    );

    modport slave (
        output run, opcode, mem_ready,
        input  pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op, mem_err, state
    );

endinterface

// File: rtl/mips_mem_wait_timer.sv
// Memory-wait counter: counts cycles spent in a memory state without
// mem_ready and flags the cycle on which the wait limit is reached.
module mips_mem_wait_timer #(
    parameter int unsigned TIMEOUT_W   = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    input  logic mem_ready,
    output logic timeout
);

    logic [TIMEOUT_W-1:0] cnt;

    assign timeout = count && !mem_ready && (cnt == TIMEOUT_W'(MEM_TIMEOUT));

    // Restart on completion or abort so every memory-state entry sees zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clear || mem_ready || timeout) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + TIMEOUT_W'(1);
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM. Sequences fetch/decode/execute/
// memory/writeback and drives datapath selects and enables.
// Optional: define CTRL_ADDI_EN to add the addi (opcode 8) path.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_W   = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    mips_multicycle_ctrl_if.master bus
);

    state_t state, next_state;
    logic   in_mem;
    logic   timeout;

    assign in_mem = is_mem_state(state);

    mips_mem_wait_timer #(
        .TIMEOUT_W   (TIMEOUT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!in_mem),
        .count     (in_mem),
        .mem_ready (bus.mem_ready),
        .timeout   (timeout)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and Moore output decode (memory states gated by mem_ready).
    always_comb begin
        next_state       = state;
        bus.pc_write     = 1'b0;
        bus.pc_write_beq = 1'b0;
        bus.pc_write_bne = 1'b0;
        bus.i_or_d       = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.ir_write     = 1'b0;
        bus.reg_dst      = DST_RT;
        bus.mem_to_reg   = WB_ALUOUT;
        bus.reg_write    = 1'b0;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = SRCB_B;
        bus.alu_op       = ALU_ADD;
        bus.pc_source    = PC_ALU;
        bus.illegal_op   = 1'b0;
        bus.mem_err      = timeout;
        bus.state        = state;

        unique case (state)
            S_IDLE: begin
                if (bus.run) next_state = S_FETCH;
            end
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                if (!bus.run) begin
                    next_state = S_IDLE;
                end else if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    next_state   = S_DECODE;
                end else if (timeout) begin
                    next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMM_SH2;
                case (bus.opcode)
                    OP_LW, OP_SW:   next_state = S_MEMADR;
                    OP_RTYPE:       next_state = S_EXEC;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:           next_state = S_JUMP;
                    OP_JAL:         next_state = S_JAL;
`ifdef CTRL_ADDI_EN
                    OP_ADDI:        next_state = S_ADDIEX;
`endif
                    default: begin
                        bus.illegal_op = 1'b1;
                        next_state     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                next_state    = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready)  next_state = S_MEMWB;
                else if (timeout)   next_state = S_FETCH;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = DST_RT;
                bus.mem_to_reg = WB_MDR;
                next_state     = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (bus.mem_ready || timeout) next_state = S_FETCH;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_B;
                bus.alu_op    = ALU_FUNCT;
                next_state    = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = DST_RD;
                bus.mem_to_reg = WB_ALUOUT;
                next_state     = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a    = 1'b1;
                bus.alu_src_b    = SRCB_B;
                bus.alu_op       = ALU_SUB;
                bus.pc_source    = PC_ALUOUT;
                bus.pc_write_beq = (bus.opcode == OP_BEQ);
                bus.pc_write_bne = (bus.opcode == OP_BNE);
                next_state       = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PC_JUMP;
                next_state    = S_FETCH;
            end
            S_JAL: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = DST_RA;
                bus.mem_to_reg = WB_PC;
                bus.pc_write   = 1'b1;
                bus.pc_source  = PC_JUMP;
                next_state     = S_FETCH;
            end
`ifdef CTRL_ADDI_EN
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                next_state    = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = DST_RT;
                bus.mem_to_reg = WB_ALUOUT;
                next_state     = S_FETCH;
            end
`endif
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: builds an expected
// per-cycle trace of every instruction class from the instruction's
// step list and memory latency, then replays it against the DUT.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       mem_err;
        logic [3:0] state;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    obs_t       exp_q[$];
    logic       rdy_q[$];
    logic [5:0] op_q[$];

    mips_multicycle_ctrl_if bif ();

    mips_multicycle_ctrl #(
        .TIMEOUT_W   (4),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t sample();
        obs_t o;
        o.pc_write     = bif.pc_write;
        o.pc_write_beq = bif.pc_write_beq;
        o.pc_write_bne = bif.pc_write_bne;
        o.i_or_d       = bif.i_or_d;
        o.mem_read     = bif.mem_read;
        o.mem_write    = bif.mem_write;
        o.ir_write     = bif.ir_write;
        o.reg_dst      = bif.reg_dst;
        o.mem_to_reg   = bif.mem_to_reg;
        o.reg_write    = bif.reg_write;
        o.alu_src_a    = bif.alu_src_a;
        o.alu_src_b    = bif.alu_src_b;
        o.alu_op       = bif.alu_op;
        o.pc_source    = bif.pc_source;
        o.illegal_op   = bif.illegal_op;
        o.mem_err      = bif.mem_err;
        o.state        = bif.state;
        return o;
    endfunction

    function automatic obs_t base(input state_t s);
        obs_t o;
        o = '0;
        o.state = s;
        return o;
    endfunction

    function automatic bit known(input logic [5:0] op);
        bit k;
        k = (op == 6'd0) || (op == 6'd2) || (op == 6'd3) || (op == 6'd4) ||
            (op == 6'd5) || (op == 6'd35) || (op == 6'd43);
`ifdef CTRL_ADDI_EN
        k = k || (op == 6'd8);
`endif
        return k;
    endfunction

    task automatic push(input obs_t o, input logic r, input logic [5:0] op);
        exp_q.push_back(o);
        rdy_q.push_back(r);
        op_q.push_back(op);
    endtask

    // Non-memory cycle: mem_ready is noise that must have no effect.
    task automatic push_nm(input obs_t o, input logic [5:0] op);
        push(o, 1'($urandom_range(0, 1)), op);
    endtask

    // A memory state: either lat idle cycles then completion, or an abort
    // after 16 cycles without ready (error flagged on the last one).
    task automatic gen_access(input obs_t w, input obs_t d, input int unsigned lat,
                              input bit to, input logic [5:0] op);
        obs_t e;
        if (to) begin
            repeat (15) push(w, 1'b0, op);
            e = w;
            e.mem_err = 1'b1;
            push(e, 1'b0, op);
        end else begin
            repeat (lat) push(w, 1'b0, op);
            push(d, 1'b1, op);
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input int unsigned flat, input bit fto,
                             input int unsigned dlat, input bit dto);
        obs_t f, fd, o, d;
        f = base(S_FETCH);
        f.mem_read  = 1'b1;
        f.alu_src_b = 2'd1;
        fd = f;
        fd.ir_write = 1'b1;
        fd.pc_write = 1'b1;
        gen_access(f, fd, flat, fto, op);
        if (fto) return;
        o = base(S_DECODE);
        o.alu_src_b = 2'd3;
        if (!known(op)) begin
            o.illegal_op = 1'b1;
            push_nm(o, op);
            return;
        end
        push_nm(o, op);
        if (op == 6'd35 || op == 6'd43) begin
            o = base(S_MEMADR);
            o.alu_src_a = 1'b1;
            o.alu_src_b = 2'd2;
            push_nm(o, op);
            if (op == 6'd35) begin
                o = base(S_MEMRD);
                o.mem_read = 1'b1;
                o.i_or_d   = 1'b1;
                gen_access(o, o, dlat, dto, op);
                if (!dto) begin
                    o = base(S_MEMWB);
                    o.reg_write  = 1'b1;
                    o.mem_to_reg = 2'd1;
                    push_nm(o, op);
                end
            end else begin
                o = base(S_MEMWR);
                o.mem_write = 1'b1;
                o.i_or_d    = 1'b1;
                gen_access(o, o, dlat, dto, op);
            end
        end else if (op == 6'd0) begin
            o = base(S_EXEC);
            o.alu_src_a = 1'b1;
            o.alu_op    = 2'd2;
            push_nm(o, op);
            d = base(S_ALUWB);
            d.reg_write = 1'b1;
            d.reg_dst   = 2'd1;
            push_nm(d, op);
        end else if (op == 6'd4 || op == 6'd5) begin
            o = base(S_BRANCH);
            o.alu_src_a    = 1'b1;
            o.alu_op       = 2'd1;
            o.pc_source    = 2'd1;
            o.pc_write_beq = (op == 6'd4);
            o.pc_write_bne = (op == 6'd5);
            push_nm(o, op);
        end else if (op == 6'd2) begin
            o = base(S_JUMP);
            o.pc_write  = 1'b1;
            o.pc_source = 2'd2;
            push_nm(o, op);
        end else if (op == 6'd3) begin
            o = base(S_JAL);
            o.reg_write  = 1'b1;
            o.reg_dst    = 2'd2;
            o.mem_to_reg = 2'd2;
            o.pc_write   = 1'b1;
            o.pc_source  = 2'd2;
            push_nm(o, op);
        end else begin
            o = base(S_ADDIEX);
            o.alu_src_a = 1'b1;
            o.alu_src_b = 2'd2;
            push_nm(o, op);
            d = base(S_ADDIWB);
            d.reg_write = 1'b1;
            push_nm(d, op);
        end
    endtask

    task automatic exec_q(input string name);
        obs_t e, got;
        logic r;
        logic [5:0] op;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            r  = rdy_q.pop_front();
            op = op_q.pop_front();
            @(negedge clk);
            bif.mem_ready = r;
            bif.opcode    = op;
            #1;
            got = sample();
            n_checks++;
            if (got !== e)
                $display("FAIL %s cyc %0d: got=%h exp=%h (state got %0d exp %0d)",
                         name, cyc, got, e, got.state, e.state);
            else
                n_pass++;
        end
    endtask

    // Leaves the DUT in IDLE just after reset release, at a negedge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bif.run = 1'b1;
        bif.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got;
        @(negedge clk);
        rst_n = 1'b0;
        bif.run = 1'b1;
        bif.mem_ready = 1'b1;
        bif.opcode = 6'd63;
        repeat (2) @(negedge clk);
        #1;
        got = sample();
        n_checks++;
        if (got !== base(S_IDLE)) $display("FAIL reset_idle: got=%h exp=%h", got, base(S_IDLE));
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        bif.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        got = sample();
        n_checks++;
        if (got.state !== 4'(S_FETCH) || got.mem_read !== 1'b1)
            $display("FAIL reset_release: got state=%0d mem_read=%b exp state=%0d mem_read=1",
                     got.state, got.mem_read, S_FETCH);
        else n_pass++;
    endtask

    task automatic test_lw();
        do_reset();
        gen_instr(6'd35, 0, 0, 0, 0);
        exec_q("lw_fast");
    endtask

    task automatic test_sw_delayed();
        do_reset();
        gen_instr(6'd43, 0, 0, 3, 0);
        exec_q("sw_delayed");
    endtask

    task automatic test_branch_jump();
        do_reset();
        gen_instr(6'd4, 0, 0, 0, 0);
        gen_instr(6'd5, 1, 0, 0, 0);
        gen_instr(6'd3, 0, 0, 0, 0);
        gen_instr(6'd2, 0, 0, 0, 0);
        gen_instr(6'd0, 2, 0, 0, 0);
        exec_q("branch_jump");
    endtask

    task automatic test_timeout();
        do_reset();
        gen_instr(6'd0, 0, 1, 0, 0);
        gen_instr(6'd0, 15, 0, 0, 0);
        gen_instr(6'd35, 0, 0, 0, 1);
        gen_instr(6'd43, 0, 0, 15, 0);
        gen_instr(6'd43, 0, 0, 0, 1);
        gen_instr(6'd2, 0, 0, 0, 0);
        exec_q("timeout");
    endtask

    task automatic test_illegal();
        do_reset();
        gen_instr(6'd63, 0, 0, 0, 0);
        gen_instr(6'd8, 0, 0, 0, 0);
        gen_instr(6'd1, 0, 0, 0, 0);
        gen_instr(6'd0, 0, 0, 0, 0);
        exec_q("illegal");
    endtask

    task automatic test_reset_mid_access();
        obs_t got;
        do_reset();
        gen_instr(6'd43, 0, 0, 20, 0);
        // Keep only the fetch, decode, address and three waiting write cycles.
        while (exp_q.size() > 6) begin
            void'(exp_q.pop_back());
            void'(rdy_q.pop_back());
            void'(op_q.pop_back());
        end
        exec_q("mid_access");
        @(negedge clk);
        rst_n = 1'b0;
        bif.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        got = sample();
        n_checks++;
        if (got !== base(S_IDLE))
            $display("FAIL reset_mid_access: got=%h exp=%h", got, base(S_IDLE));
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[10];
        logic [5:0] op;
        int unsigned flat, dlat;
        bit fto, dto;
        ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd35, 6'd43, 6'd63, 6'd0};
        do_reset();
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            flat = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
            dlat = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
            fto = ($urandom_range(0, 9) == 0);
            dto = ($urandom_range(0, 7) == 0);
            gen_instr(op, flat, fto, dlat, dto);
        end
        exec_q("back_to_back");
    endtask

    initial begin
        rst_n = 1'b0;
        bif.run = 1'b0;
        bif.opcode = '0;
        bif.mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_sw_delayed();
        test_branch_jump();
        test_timeout();
        test_illegal();
        test_reset_mid_access();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang exp finish");
        $fatal(1);
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS core; replaces the single-cycle decoder when the datapath shares one ALU and one memory port across cycles.
- Sequences fetch, decode, execute, memory and writeback per instruction.
- Drives the datapath mux selects and write enables.
- Handshakes with a variable-latency unified memory.

Parameters:
- TIMEOUT_W, 4: width of the memory-wait counter.
- MEM_TIMEOUT, 15: maximum cycles to wait for mem_ready in any memory state before aborting. Must be ≤ 2^TIMEOUT_W−1 and ≥ 1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  level; FSM leaves IDLE and fetches only while high.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_beq  out  1  PC load if ALU zero.
- pc_write_bne  out  1  PC load if ALU not zero.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  2  write register select: 0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  out  2  write data select: 0 = ALUOut, 1 = MDR, 2 = PC.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 0 = B, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2.
- alu_op  out  2  ALU op: 0 = add, 1 = sub, 2 = funct field.
- pc_source  out  2  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.
- mem_err  out  1  one-cycle pulse on memory timeout.
- state  out  4  current state, for debug.

Behaviour:
- Reset:
  - Synchronous: when rst_n is low at a clk edge, state := IDLE, timer := 0, both pulses cleared.
  - A reset mid-access drops mem_read/mem_write the next cycle; no writeback occurs.
- Outputs:
  - All outputs are Moore decodes of the state (plus mem_ready gating, below).
  - Default value of every enable/select is 0.
- States and transitions:
  - IDLE: run=1 → FETCH.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
    - ir_write and pc_write are asserted only in the cycle mem_ready=1; then → DECODE.
    - If run=0 on entry, → IDLE instead.
  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut). Next state by opcode:
    - lw(35), sw(43) → MEMADR.
    - R(0) → EXEC.
    - beq(4), bne(5) → BRANCH.
    - j(2) → JUMP.
    - jal(3) → JAL.
    - Any other opcode: illegal_op=1 for that cycle, → FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. lw → MEMRD; sw → MEMWR.
  - MEMRD: mem_read=1, i_or_d=1; wait for mem_ready → MEMWB.
  - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
  - MEMWR: mem_write=1, i_or_d=1; on mem_ready → FETCH.
  - EXEC: alu_src_a=1, alu_src_b=0, alu_op=2 → ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1; pc_write_beq (beq) or pc_write_bne (bne) → FETCH.
  - JUMP: pc_write=1, pc_source=2 → FETCH.
  - JAL: reg_write=1, reg_dst=2, mem_to_reg=2 (PC already +4), pc_write=1, pc_source=2 → FETCH.
- Memory handshake:
  - mem_read/mem_write are held steady until mem_ready is sampled high.
  - Exactly one transfer completes per memory state visit.
  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Minimum latency with mem_ready tied high: R=4, lw=5, sw=4, beq/bne=3, j=3, jal=3 cycles.
- Timeout:
  - The timer clears on entry to each memory state and increments each cycle mem_ready=0.
  - At timer == MEM_TIMEOUT with mem_ready still 0: mem_err=1, → FETCH (FETCH re-enters with PC unchanged), no IR, register or PC write.
  - If mem_ready=1 on the timeout cycle, the access completes normally; no error.

Optional Feature:
- CTRL_ADDI_EN defined:
  - opcode addi(8) in DECODE → ADDIEX (alu_src_a=1, alu_src_b=2, alu_op=0) → ADDIWB (reg_write=1, reg_dst=0, mem_to_reg=0) → FETCH; 4 cycles.
- Undefined: opcode 8 is illegal (illegal_op pulse, → FETCH).

Decomposition:
- Package mips_ctrl_pkg holds:
  - Opcode localparams.
  - State encoding.
  - alu_src_b, alu_op, pc_source, reg_dst and mem_to_reg encodings.
- Sub-module mips_mem_wait_timer: inputs clear, count, mem_ready; output timeout. Parameterised by TIMEOUT_W and MEM_TIMEOUT.

Test Plan:
- Reset/IDLE: rst_n=0 for 2 cycles with run=1 → all outputs 0, state=IDLE; release → FETCH next cycle, mem_read=1.
- lw, mem_ready high: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; reg_write=1 only in MEMWB with mem_to_reg=1.
- sw with mem_ready delayed 3 cycles: mem_write high for 4 consecutive cycles, then FETCH; reg_write never 1.
- beq and bne: pc_write_beq=1 (beq) or pc_write_bne=1 (bne) only in BRANCH, alu_op=1; jal gives reg_dst=2, mem_to_reg=2, pc_write=1 in one cycle.
- Timeout: mem_ready=0 during FETCH with MEM_TIMEOUT=15 → mem_err pulse at the 16th FETCH cycle, no ir_write, re-enter FETCH.
- Illegal opcode 63 (and 8 without CTRL_ADDI_EN) → illegal_op one-cycle pulse in DECODE, next state FETCH; with CTRL_ADDI_EN, opcode 8 → ADDIWB with reg_dst=0.
